// File: rtl/pcileech_tlps128_multibar_controller.sv
// Multi-BAR controller: one request/response port serving NUM_BARS local
// block-RAM apertures, with the BAR0 config-shadow and MSI-X windows routed
// to an external target port.
// Optional build macro PCILEECH_BAR_EXT_TIMEOUT_EN: when defined, an external
// read that sees no ext_rvalid within EXT_TIMEOUT cycles completes with an
// error response; when undefined the controller waits for ext_rvalid forever.
module pcileech_tlps128_multibar_controller #(
  parameter int          NUM_BARS       = 2,
  parameter int          APERTURE_LOG2  = 17,
  parameter int          RD_LATENCY     = 2,
  parameter logic [31:0] MSIX_OFFSET    = 32'h1000,
  parameter int          MSIX_SIZE_LOG2 = 12,
  parameter int          EXT_TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_bar,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        ext_req,
  output logic        ext_sel,
  output logic        ext_we,
  output logic [11:0] ext_addr,
  output logic [3:0]  ext_be,
  output logic [31:0] ext_wdata,
  input  logic [31:0] ext_rdata,
  input  logic        ext_rvalid,
  output logic [15:0] err_count
);

  localparam int          WORDS_LOG2 = APERTURE_LOG2 - 2;
  localparam int          DEPTH      = NUM_BARS << WORDS_LOG2;
  localparam int          IDX_W      = $clog2(DEPTH);
  localparam int          CNT_MAX    = (EXT_TIMEOUT > RD_LATENCY) ? EXT_TIMEOUT : RD_LATENCY;
  localparam int          CNT_W      = $clog2(CNT_MAX + 1);
  localparam logic [32:0] MSIX_LO    = {1'b0, MSIX_OFFSET};
  localparam logic [32:0] MSIX_HI    = MSIX_LO + (33'd1 << MSIX_SIZE_LOG2);
  localparam logic [32:0] APER_END   = 33'd1 << APERTURE_LOG2;
  localparam logic [31:0] ERR_DATA   = 32'hDEADBEEF;

  typedef enum logic [1:0] {IDLE, MEM_RD, EXT_RD, ERR_RSP} state_t;
  typedef enum logic [1:0] {DEC_MEM, DEC_CFG, DEC_MSIX, DEC_ERR} dec_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               ready_reg, ready_next;
  logic               rsp_valid_reg, rsp_valid_next;
  logic               rsp_err_reg, rsp_err_next;
  logic [31:0]        rsp_data_reg, rsp_data_next;
  logic               mem_sel_reg, mem_sel_next;
  logic               ext_req_reg, ext_req_next;
  logic               ext_sel_reg, ext_sel_next;
  logic               ext_we_reg, ext_we_next;
  logic [11:0]        ext_addr_reg, ext_addr_next;
  logic [3:0]         ext_be_reg, ext_be_next;
  logic [31:0]        ext_wdata_reg, ext_wdata_next;
  logic [15:0]        err_count_reg, err_count_next;
  logic [15:0]        err_inc;

  dec_t               dec;
  logic               accept;
  logic               mem_wr;
  logic               mem_rd;
  logic [IDX_W-1:0]   mem_idx;
  logic [31:0]        rd_word;
  logic [31:0]        mem_tap;

  assign accept  = req_valid && ready_reg;
  assign err_inc = (err_count_reg == 16'hFFFF) ? 16'hFFFF : err_count_reg + 16'd1;

  // Classify the presented request; the config shadow takes priority over MSI-X.
  always_comb begin
    dec = DEC_ERR;
    if (req_bar == 3'd0 && req_addr[31:12] == 20'hFFFFF)
      dec = DEC_CFG;
    else if (req_bar == 3'd0 && {1'b0, req_addr} >= MSIX_LO && {1'b0, req_addr} < MSIX_HI)
      dec = DEC_MSIX;
    else if (int'(req_bar) < NUM_BARS && {1'b0, req_addr} < APER_END)
      dec = DEC_MEM;
  end

  // Flat word index: each BAR owns a contiguous slice of the shared RAM.
  always_comb begin
    mem_idx = IDX_W'((int'(req_bar) << WORDS_LOG2) + int'(req_addr[APERTURE_LOG2-1:2]));
  end

  // One RAM per byte lane gives byte-enable writes with a registered read port.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] rd_byte;

    // Lane write on accepted byte-enabled write; registered read on accepted read.
    always_ff @(posedge clk) begin
      if (mem_wr && req_be[gi])
        lane_mem[mem_idx] <= req_wdata[8*gi +: 8];
      if (mem_rd)
        rd_byte <= lane_mem[mem_idx];
    end

    assign rd_word[8*gi +: 8] = rd_byte;
  end

  // Extra read stages so the response lands exactly RD_LATENCY cycles after acceptance.
  if (RD_LATENCY <= 2) begin : g_tap_direct
    assign mem_tap = rd_word;
  end else begin : g_tap_pipe
    logic [31:0] dly_reg [RD_LATENCY-2];

    // Shift the read word down the delay line every cycle.
    always_ff @(posedge clk) begin
      dly_reg[0] <= rd_word;
      for (int i = 1; i < RD_LATENCY - 2; i++)
        dly_reg[i] <= dly_reg[i-1];
    end

    assign mem_tap = dly_reg[RD_LATENCY-3];
  end

  // Next-state and next-output logic of the request FSM.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    rsp_valid_next = 1'b0;
    rsp_err_next   = 1'b0;
    rsp_data_next  = rsp_data_reg;
    mem_sel_next   = mem_sel_reg;
    ext_req_next   = 1'b0;
    ext_sel_next   = ext_sel_reg;
    ext_we_next    = ext_we_reg;
    ext_addr_next  = ext_addr_reg;
    ext_be_next    = ext_be_reg;
    ext_wdata_next = ext_wdata_reg;
    err_count_next = err_count_reg;
    mem_wr         = 1'b0;
    mem_rd         = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          unique case (dec)
            DEC_MEM: begin
              mem_wr = req_we;
              mem_rd = !req_we;
              if (!req_we) begin
                state_next = MEM_RD;
                cnt_next   = '0;
                // With single-cycle latency the RAM output register is the response.
                if (RD_LATENCY == 1) begin
                  rsp_valid_next = 1'b1;
                  mem_sel_next   = 1'b1;
                end
              end
            end
            DEC_CFG, DEC_MSIX: begin
              ext_req_next   = 1'b1;
              ext_sel_next   = (dec == DEC_MSIX);
              ext_we_next    = req_we;
              ext_addr_next  = {req_addr[11:2], 2'b00};
              ext_be_next    = req_be;
              ext_wdata_next = req_wdata;
              if (!req_we) begin
                state_next = EXT_RD;
                cnt_next   = '0;
              end
            end
            default: begin
              err_count_next = err_inc;
              if (!req_we) begin
                rsp_valid_next = 1'b1;
                rsp_err_next   = 1'b1;
                rsp_data_next  = ERR_DATA;
                mem_sel_next   = 1'b0;
                state_next     = ERR_RSP;
              end
            end
          endcase
        end
      end

      MEM_RD: begin
        cnt_next = cnt_reg + 1'b1;
        if (RD_LATENCY >= 2 && cnt_reg == CNT_W'(RD_LATENCY - 2)) begin
          rsp_valid_next = 1'b1;
          rsp_data_next  = mem_tap;
          mem_sel_next   = 1'b0;
        end
        // Stay busy through the response cycle.
        if (cnt_reg == CNT_W'(RD_LATENCY - 1))
          state_next = IDLE;
      end

      EXT_RD: begin
        if (ext_rvalid) begin
          rsp_valid_next = 1'b1;
          rsp_data_next  = ext_rdata;
          mem_sel_next   = 1'b0;
          state_next     = IDLE;
        end
`ifdef PCILEECH_BAR_EXT_TIMEOUT_EN
        else if (cnt_reg == CNT_W'(EXT_TIMEOUT - 1)) begin
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
          rsp_data_next  = ERR_DATA;
          mem_sel_next   = 1'b0;
          err_count_next = err_inc;
          state_next     = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
`endif
      end

      ERR_RSP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    ready_next = (state_next == IDLE);
  end

  // State and registered outputs; everything observable clears on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      ready_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_data_reg  <= '0;
      mem_sel_reg   <= 1'b0;
      ext_req_reg   <= 1'b0;
      ext_sel_reg   <= 1'b0;
      ext_we_reg    <= 1'b0;
      ext_addr_reg  <= '0;
      ext_be_reg    <= '0;
      ext_wdata_reg <= '0;
      err_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      ready_reg     <= ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_data_reg  <= rsp_data_next;
      mem_sel_reg   <= mem_sel_next;
      ext_req_reg   <= ext_req_next;
      ext_sel_reg   <= ext_sel_next;
      ext_we_reg    <= ext_we_next;
      ext_addr_reg  <= ext_addr_next;
      ext_be_reg    <= ext_be_next;
      ext_wdata_reg <= ext_wdata_next;
      err_count_reg <= err_count_next;
    end
  end

  assign req_ready = ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_data  = mem_sel_reg ? rd_word : rsp_data_reg;
  assign ext_req   = ext_req_reg;
  assign ext_sel   = ext_sel_reg;
  assign ext_we    = ext_we_reg;
  assign ext_addr  = ext_addr_reg;
  assign ext_be    = ext_be_reg;
  assign ext_wdata = ext_wdata_reg;
  assign err_count = err_count_reg;

endmodule

// File: doc/pcileech_tlps128_multibar_controller.md
Name: pcileech_tlps128_multibar_controller

Overview:
Parametrised successor BAR controller serving up to NUM_BARS memory BARs from one request/response interface. Each BAR is backed by a local block-RAM aperture with byte-enable writes and a fixed-latency read pipeline. Two windows in BAR0 are routed to an external target port: the configuration-space shadow (top 4 KB) and the MSI-X table/PBA (MSIX_OFFSET). The block sits between the TLP decode/completion logic and the cfgspace shadow / MSI-X blocks.

Parameters:
NUM_BARS, 2, number of implemented BARs (1..6)
APERTURE_LOG2, 17, log2 of bytes per BAR aperture (12..20), identical for all BARs
RD_LATENCY, 2, local-memory read latency in cycles (1..4)
MSIX_OFFSET, 32'h1000, byte offset of MSI-X window in BAR0, 4 KB aligned
MSIX_SIZE_LOG2, 12, log2 of MSI-X window bytes
EXT_TIMEOUT, 255, cycles to wait for ext_rvalid before error (used only with optional feature)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous reset, active low
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_bar  in  3  target BAR index
req_addr  in  32  byte offset within BAR, [1:0] ignored
req_we  in  1  1=write, 0=read
req_be  in  4  write byte enables
req_wdata  in  32  write data
rsp_valid  out  1  read response strobe, one cycle
rsp_data  out  32  read data
rsp_err  out  1  read error qualifier with rsp_valid
ext_req  out  1  external access strobe, one cycle
ext_sel  out  1  0=cfg shadow, 1=MSI-X
ext_we  out  1  external write
ext_addr  out  12  external dword-aligned byte offset
ext_be  out  4  external byte enables
ext_wdata  out  32  external write data
ext_rdata  in  32  external read data
ext_rvalid  in  1  external read data valid
err_count  out  16  saturating count of decode errors

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE; req_ready=0 during reset, 1 first cycle after; rsp_valid=0, rsp_data=0, rsp_err=0, ext_req=0, all ext_* outputs 0, err_count=0. Memory contents not reset; initialised to zero at configuration.
- Decode at acceptance: CFG if req_bar==0 && req_addr[31:12]==20'hFFFFF; MSIX if req_bar==0 && req_addr in [MSIX_OFFSET, MSIX_OFFSET+2^MSIX_SIZE_LOG2); MEM if req_bar<NUM_BARS && req_addr < 2^APERTURE_LOG2; else ERR. CFG wins over MSIX.
- FSM: IDLE (req_ready=1), MEM_RD, EXT_RD, ERR_RSP. Single outstanding read; req_ready=0 outside IDLE.
- Write MEM: performed cycle after acceptance, only bytes with req_be set; stay IDLE; no response.
- Write CFG/MSIX: ext_req=1, ext_we=1 for one cycle after acceptance; ext_addr = req_addr[11:0] relative to window base; stay IDLE.
- Write ERR: dropped, err_count++; stay IDLE.
- Read MEM: -> MEM_RD; rsp_valid exactly RD_LATENCY cycles after acceptance, rsp_err=0; -> IDLE same cycle, so next request accepted cycle after rsp_valid.
- Read CFG/MSIX: ext_req=1, ext_we=0 one cycle after acceptance; -> EXT_RD; first ext_rvalid captured; rsp_valid next cycle with rsp_data=ext_rdata, rsp_err=0; -> IDLE. ext_rvalid outside EXT_RD ignored.
- Read ERR: -> ERR_RSP; rsp_valid next cycle, rsp_data=32'hDEADBEEF, rsp_err=1; err_count++.
- err_count saturates at 16'hFFFF.
- rsp_data holds last value when rsp_valid=0.
- Reset mid-operation: pending read abandoned, no rsp_valid issued; in-flight memory write may or may not commit.

Optional Feature:
PCILEECH_BAR_EXT_TIMEOUT_EN: defined -> EXT_RD counts cycles; if EXT_TIMEOUT cycles pass without ext_rvalid, rsp_valid with rsp_data=32'hDEADBEEF, rsp_err=1, err_count++, -> IDLE; counter cleared on entry to EXT_RD. Undefined -> EXT_RD waits indefinitely; EXT_TIMEOUT unused.

Test Plan:
Write BAR1 addr 0x40 data 0xA5A5A5A5 be 4'b0101, then read -> rsp_valid exactly 2 cycles after accept, data 0x00A500A5, rsp_err=0.
Read BAR0 addr 0xFFFFF010, ext_rvalid 5 cycles later with 0x12345678 -> ext_req/ext_sel=0/ext_addr=0x010 one cycle after accept; rsp_data 0x12345678 cycle after ext_rvalid.
Write BAR0 addr 0x1008 data 0xCAFEBABE -> ext_req=1, ext_sel=1, ext_we=1, ext_addr=0x008, ext_wdata=0xCAFEBABE; no rsp_valid.
Read BAR5 (NUM_BARS=2) and read BAR1 addr 0x20000 -> each rsp 0xDEADBEEF, rsp_err=1; err_count=2.
With macro, EXT_TIMEOUT=8: CFG read, ext_rvalid never asserted -> rsp_err=1, 0xDEADBEEF after 8 cycles in EXT_RD; req_ready returns 1.
Assert reset_n low during MEM_RD -> no rsp_valid, all outputs 0 immediately; after release, read of earlier written address returns stored value.
